// File: rtl/pipe_ctrl_if.sv
// Request/response bundle between the 5-stage pipeline and its sequencer.
// Optional perf counter signals exist only when CTRL_PERF_CNT_EN is defined.
interface pipe_ctrl_if;
  // Requests are single-cycle level pulses sampled on the rising edge (no
  // valid/ready back-pressure): exc_vector/epc are only meaningful in the
  // cycle their request is high; new_pc is only meaningful while flush=1.
  logic        stallreq_id;
  logic        stallreq_ex;
  logic        stallreq_mem;
  logic        exc_req;
  logic [31:0] exc_vector;
  logic        eret_req;
  logic [31:0] epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        stall_timeout;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] perf_stall_cyc;
  logic [15:0] perf_flush_cnt;
`endif

  modport master (
    output stallreq_id, stallreq_ex, stallreq_mem,
    output exc_req, exc_vector, eret_req, epc,
    input  stall, flush, new_pc, stall_timeout
`ifdef CTRL_PERF_CNT_EN
    , input perf_stall_cyc, perf_flush_cnt
`endif
  );

  modport slave (
    input  stallreq_id, stallreq_ex, stallreq_mem,
    input  exc_req, exc_vector, eret_req, epc,
    output stall, flush, new_pc, stall_timeout
`ifdef CTRL_PERF_CNT_EN
    , output perf_stall_cyc, perf_flush_cnt
`endif
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: stall merge, exception/ERET flush + redirect, blanking, stall watchdog.
// Define CTRL_PERF_CNT_EN to add the stall-cycle and flush perf counters.
module pipe_ctrl #(
  parameter int unsigned BLANK_CYCLES = 3,
  parameter int unsigned MAX_STALL    = 255
) (
  input  logic       clk,
  input  logic       rst,
  pipe_ctrl_if.slave bus,
  output logic [1:0] o_dbg_state
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_BLANK = 2'd2
  } state_t;

  localparam logic [3:0]  BLANK_INIT = 4'(BLANK_CYCLES - 1);
  localparam logic [15:0] STALL_MAX  = 16'(MAX_STALL);

  state_t      r_state;
  state_t      w_state_next;
  logic        r_flush;
  logic        w_flush_next;
  logic [31:0] r_new_pc;
  logic [31:0] w_new_pc_next;
  logic [3:0]  r_blank_cnt;
  logic [3:0]  w_blank_cnt_next;
  logic [15:0] r_stall_cnt;
  logic [15:0] w_stall_cnt_next;
  logic        r_stall_timeout;
  logic [5:0]  w_stall;

  // The deepest requesting stage freezes itself and everything upstream.
  always_comb begin
    w_stall = 6'b000000;
    if (r_flush)               w_stall = 6'b000000;
    else if (bus.stallreq_mem) w_stall = 6'b011111;
    else if (bus.stallreq_ex)  w_stall = 6'b001111;
    else if (bus.stallreq_id)  w_stall = 6'b000111;
  end

  always_comb begin
    w_state_next     = r_state;
    w_flush_next     = 1'b0;
    w_new_pc_next    = r_new_pc;
    w_blank_cnt_next = r_blank_cnt;
    case (r_state)
      ST_RUN: begin
        if (bus.exc_req) begin
          w_state_next  = ST_FLUSH;
          w_flush_next  = 1'b1;
          w_new_pc_next = bus.exc_vector;
        end else if (bus.eret_req) begin
          w_state_next  = ST_FLUSH;
          w_flush_next  = 1'b1;
          w_new_pc_next = bus.epc;
        end
      end
      ST_FLUSH: begin
        w_state_next     = ST_BLANK;
        w_blank_cnt_next = BLANK_INIT;
      end
      ST_BLANK: begin
        // Bubbles are still draining; a fresh exception here would be spurious.
        if (r_blank_cnt == 4'd0) w_state_next = ST_RUN;
        else                     w_blank_cnt_next = r_blank_cnt - 4'd1;
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  always_comb begin
    w_stall_cnt_next = r_stall_cnt;
    if (r_flush || !w_stall[0])     w_stall_cnt_next = 16'd0;
    else if (r_stall_cnt != STALL_MAX) w_stall_cnt_next = r_stall_cnt + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_RUN;
      r_flush         <= 1'b0;
      r_new_pc        <= 32'd0;
      r_blank_cnt     <= 4'd0;
      r_stall_cnt     <= 16'd0;
      r_stall_timeout <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_flush         <= w_flush_next;
      r_new_pc        <= w_new_pc_next;
      r_blank_cnt     <= w_blank_cnt_next;
      r_stall_cnt     <= w_stall_cnt_next;
      r_stall_timeout <= (w_stall_cnt_next == STALL_MAX);
    end
  end

  assign bus.stall         = w_stall;
  assign bus.flush         = r_flush;
  assign bus.new_pc        = r_new_pc;
  assign bus.stall_timeout = r_stall_timeout;
  assign o_dbg_state       = r_state;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] r_perf_stall_cyc;
  logic [15:0] r_perf_flush_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall_cyc <= 32'd0;
      r_perf_flush_cnt <= 16'd0;
    end else begin
      if (w_stall[0]) r_perf_stall_cyc <= r_perf_stall_cyc + 32'd1;
      if (r_flush)    r_perf_flush_cnt <= r_perf_flush_cnt + 16'd1;
    end
  end

  assign bus.perf_stall_cyc = r_perf_stall_cyc;
  assign bus.perf_flush_cnt = r_perf_flush_cnt;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed literal cases, then random traffic against a cycle-level model.
// Perf counter checks are active when CTRL_PERF_CNT_EN is defined.
module tb_pipe_ctrl;
  localparam int BLANK = 3;
  localparam int MAXS  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;
  logic       chk_en = 1'b0;
  int         n_checks = 0;
  int         n_pass = 0;

  pipe_ctrl_if bus();

  pipe_ctrl #(.BLANK_CYCLES(BLANK), .MAX_STALL(MAXS)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic go();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // Reference model: flush follows an accepted request by one cycle; a request
  // is accepted only if more than BLANK cycles have passed since the last flush.
  logic [31:0] exp_q[$];
  logic        m_flush = 1'b0;
  logic [31:0] m_new_pc = 32'd0;
  int          m_last_flush = -1000;
  int          m_run = 0;
  int          m_cyc = 0;
  logic [31:0] m_perf_stall = 32'd0;
  logic [15:0] m_perf_flush = 16'd0;

  function automatic logic [5:0] ref_stall(input logic fl, input logic id, input logic ex, input logic mem);
    if (fl)  return 6'h00;
    if (mem) return 6'h1f;
    if (ex)  return 6'h0f;
    if (id)  return 6'h07;
    return 6'h00;
  endfunction

  always @(negedge clk) begin
    logic [5:0] e_stall;
    e_stall = ref_stall(m_flush, bus.stallreq_id, bus.stallreq_ex, bus.stallreq_mem);
    if (chk_en) begin
      chk("m_stall", {26'd0, bus.stall}, {26'd0, e_stall});
      chk("m_flush", {31'd0, bus.flush}, {31'd0, m_flush});
      chk("m_new_pc", bus.new_pc, m_new_pc);
      chk("m_timeout", {31'd0, bus.stall_timeout}, (m_run >= MAXS) ? 32'd1 : 32'd0);
`ifdef CTRL_PERF_CNT_EN
      chk("m_perf_stall", bus.perf_stall_cyc, m_perf_stall);
      chk("m_perf_flush", {16'd0, bus.perf_flush_cnt}, {16'd0, m_perf_flush});
`endif
    end
    if (rst) begin
      m_flush = 1'b0;
      m_new_pc = 32'd0;
      m_last_flush = -1000;
      m_run = 0;
      m_perf_stall = 32'd0;
      m_perf_flush = 16'd0;
      exp_q.delete();
    end else begin
      if (m_flush) m_last_flush = m_cyc;
      m_run = e_stall[0] ? m_run + 1 : 0;
      m_perf_stall = m_perf_stall + {31'd0, e_stall[0]};
      m_perf_flush = m_perf_flush + {15'd0, m_flush};
      if ((bus.exc_req || bus.eret_req) && (m_cyc - m_last_flush > BLANK))
        exp_q.push_back(bus.exc_req ? bus.exc_vector : bus.epc);
      m_flush = (exp_q.size() != 0);
      if (m_flush) m_new_pc = exp_q.pop_front();
    end
    m_cyc++;
  end

  initial begin
    bus.stallreq_id = 0; bus.stallreq_ex = 0; bus.stallreq_mem = 0;
    bus.exc_req = 0; bus.exc_vector = 0; bus.eret_req = 0; bus.epc = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    chk_en = 1;
    neg();
    chk("rst_stall", {26'd0, bus.stall}, 32'd0);
    chk("rst_flush", {31'd0, bus.flush}, 32'd0);
    chk("rst_new_pc", bus.new_pc, 32'd0);
    chk("rst_timeout", {31'd0, bus.stall_timeout}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);

    for (int i = 0; i < 3; i++) begin
      go(); bus.stallreq_id = 1;
      neg();
      chk("id_stall", {26'd0, bus.stall}, 32'h07);
      chk("id_noflush", {31'd0, bus.flush}, 32'd0);
    end
    go(); bus.stallreq_id = 0;
    neg(); chk("id_release", {26'd0, bus.stall}, 32'd0);

    go(); bus.stallreq_id = 1; bus.stallreq_mem = 1;
    neg(); chk("id_mem_prio", {26'd0, bus.stall}, 32'h1f);
    go(); bus.stallreq_id = 0; bus.stallreq_mem = 0;

    go(); bus.exc_req = 1; bus.exc_vector = 32'h20;
    neg(); chk("exc_n", {31'd0, bus.flush}, 32'd0);
    go(); bus.exc_req = 0; bus.stallreq_mem = 1;
    neg();
    chk("exc_n1_flush", {31'd0, bus.flush}, 32'd1);
    chk("exc_n1_pc", bus.new_pc, 32'h20);
    chk("exc_n1_stall", {26'd0, bus.stall}, 32'd0);
    go(); bus.stallreq_mem = 0;
    neg();
    chk("exc_n2_flush", {31'd0, bus.flush}, 32'd0);
    chk("exc_n2_pc", bus.new_pc, 32'h20);
    repeat (4) go();

    go(); bus.exc_req = 1; bus.exc_vector = 32'h20; bus.eret_req = 1; bus.epc = 32'h80001000;
    go(); bus.exc_req = 0; bus.eret_req = 0;
    neg();
    chk("both_flush", {31'd0, bus.flush}, 32'd1);
    chk("both_pc", bus.new_pc, 32'h20);
    for (int i = 0; i < 6; i++) begin
      go(); neg();
      chk("both_no_eret", {31'd0, bus.flush}, 32'd0);
    end

    go(); bus.exc_req = 1; bus.exc_vector = 32'h100;
    go(); bus.exc_req = 0;
    neg(); chk("blank_f", {31'd0, bus.flush}, 32'd1);
    go(); bus.exc_req = 1; bus.exc_vector = 32'h40;
    go(); bus.exc_req = 0;
    neg();
    chk("blank_ignore", {31'd0, bus.flush}, 32'd0);
    chk("blank_pc_hold", bus.new_pc, 32'h100);
    go();
    go(); bus.exc_req = 1; bus.exc_vector = 32'h60;
    go(); bus.exc_req = 0;
    neg();
    chk("blank_end_flush", {31'd0, bus.flush}, 32'd1);
    chk("blank_end_pc", bus.new_pc, 32'h60);
    repeat (4) go();

    bus.exc_req = 1; bus.exc_vector = 32'h200; rst = 1;
    go(); bus.exc_req = 0; rst = 0;
    neg();
    chk("rst_cancel_flush", {31'd0, bus.flush}, 32'd0);
    chk("rst_cancel_pc", bus.new_pc, 32'd0);

    go(); bus.stallreq_ex = 1;
    for (int i = 0; i < 6; i++) begin
      neg();
      chk("wd_stall", {26'd0, bus.stall}, 32'h0f);
      chk("wd_timeout", {31'd0, bus.stall_timeout}, (i >= 4) ? 32'd1 : 32'd0);
      if (i < 5) go();
    end
    go(); bus.stallreq_ex = 0;
    neg();
    chk("wd_release", {31'd0, bus.stall_timeout}, 32'd1);
`ifdef CTRL_PERF_CNT_EN
    chk("perf_stall6", bus.perf_stall_cyc, 32'd6);
    chk("perf_flush0", {16'd0, bus.perf_flush_cnt}, 32'd0);
`endif
    go(); neg();
    chk("wd_drop", {31'd0, bus.stall_timeout}, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      go();
      bus.stallreq_id  = ($urandom_range(0, 3) == 0);
      bus.stallreq_ex  = ($urandom_range(0, 1) == 0);
      bus.stallreq_mem = ($urandom_range(0, 4) == 0);
      bus.exc_req      = ($urandom_range(0, 5) == 0);
      bus.eret_req     = ($urandom_range(0, 5) == 0);
      bus.exc_vector   = $urandom;
      bus.epc          = $urandom;
      rst              = ($urandom_range(0, 299) == 0);
    end
    go();
    rst = 0;
    bus.stallreq_id = 0; bus.stallreq_ex = 0; bus.stallreq_mem = 0;
    bus.exc_req = 0; bus.eret_req = 0;
    repeat (3) go();
    neg();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
